// File: rtl/count_pattern_gen.sv
// Enumerates every 8-bit word with a requested number of ones, in ascending order,
// over a valid/ready stream. One word is produced per accepted cycle.
module count_pattern_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count_in,
  output logic       busy,
  output logic       err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_word,
  output logic [6:0] out_index,
  output logic       out_last
);

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned TZ_W   = 3;

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_idx_q;

  // Index of the final word for k ones: C(8,k)-1.
  function automatic logic [IDX_W-1:0] final_index(input logic [CNT_W-1:0] k);
    case (k)
      CNT_W'(1), CNT_W'(7): final_index = IDX_W'(7);
      CNT_W'(2), CNT_W'(6): final_index = IDX_W'(27);
      CNT_W'(3), CNT_W'(5): final_index = IDX_W'(55);
      CNT_W'(4):            final_index = IDX_W'(69);
      default:              final_index = IDX_W'(0);
    endcase
  endfunction

  // Next larger word with the same popcount: carry the lowest run of ones
  // up one place and re-pack the leftover ones at the bottom.
  logic [WORD_W-1:0] lowest;
  logic [WORD_W-1:0] ripple;
  logic [WORD_W-1:0] spread;
  logic [WORD_W-1:0] next_word;
  logic [TZ_W-1:0]   tz;

  always_comb begin
    tz = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (out_word[i]) tz = TZ_W'(i);
    end
    lowest    = out_word & (~out_word + WORD_W'(1));
    ripple    = out_word + lowest;
    spread    = WORD_W'((ripple ^ out_word) >> 2) >> tz;
    next_word = ripple | spread;
  end

  logic             illegal;
  logic [IDX_W-1:0] next_index;

  assign illegal    = count_in > CNT_W'(8);
  assign next_index = out_index + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      last_idx_q <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              state      <= EMIT;
              busy       <= 1'b1;
              out_valid  <= 1'b1;
              out_word   <= WORD_W'((9'd1 << count_in) - 9'd1);
              out_index  <= '0;
              out_last   <= (final_index(count_in) == '0);
              last_idx_q <= final_index(count_in);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
            end else begin
              out_word  <= next_word;
              out_index <= next_index;
              out_last  <= (next_index == last_idx_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_pattern_gen.sv
// Self-checking bench for count_pattern_gen against a brute-force popcount model.
module tb_count_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] count_in;
  logic       busy;
  logic       err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_word;
  logic [6:0] out_index;
  logic       out_last;

  count_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .count_in(count_in),
    .busy(busy), .err(err), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_w[$];
  logic [6:0] got_i[$];
  logic       got_l[$];
  int         stall_bad;
  int         bubbles;
  bit         timed_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: every byte with k ones, ascending.
  task automatic build_model(input int k);
    exp_q.delete();
    for (int v = 0; v < 256; v++) begin
      if ($countones(v[7:0]) == k) exp_q.push_back(v[7:0]);
    end
  endtask

  task automatic do_start(input int k);
    start    = 1'b1;
    count_in = 4'(k);
    step();
    start    = 1'b0;
  endtask

  // Records accepted beats until the last word is taken; scrambles count_in meanwhile.
  task automatic collect(input bit rnd, input int budget);
    logic [7:0] hw;
    logic [6:0] hi;
    logic       hl;
    logic       rdy;
    bit         holding;
    bit         acc;
    got_w.delete(); got_i.delete(); got_l.delete();
    stall_bad = 0; bubbles = 0; timed_out = 1'b1; holding = 1'b0;
    for (int c = 0; c < budget; c++) begin
      rdy       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (rnd) count_in = 4'($urandom_range(0, 15));
      if (!out_valid) bubbles++;
      else if (holding && (out_word !== hw || out_index !== hi || out_last !== hl)) stall_bad++;
      hw = out_word; hi = out_index; hl = out_last;
      holding = out_valid && !rdy;
      acc = out_valid && rdy;
      if (acc) begin
        got_w.push_back(out_word); got_i.push_back(out_index); got_l.push_back(out_last);
      end
      step();
      if (acc && hl === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; count_in = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last); else n_pass++;
    n_checks++; if (out_word !== 8'h00) $display("FAIL reset_word: got %h want 00", out_word); else n_pass++;
    n_checks++; if (out_index !== 7'd0) $display("FAIL reset_index: got %0d want 0", out_index); else n_pass++;
  endtask

  task automatic test_k3_stream();
    build_model(3);
    do_start(3);
    n_checks++; if (busy !== 1'b1) $display("FAIL k3_busy: got %b want 1", busy); else n_pass++;
    collect(1'b0, 200);
    n_checks++; if (timed_out) $display("FAIL k3_timeout: got timeout want completion"); else n_pass++;
    n_checks++; if (got_w.size() != 56) $display("FAIL k3_count: got %0d want 56", got_w.size()); else n_pass++;
    for (int i = 0; i < got_w.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_w[i] !== exp_q[i] || got_i[i] !== 7'(i) || got_l[i] !== (i == 55))
        $display("FAIL k3_word[%0d]: got %h/%0d/%b want %h/%0d/%b", i, got_w[i], got_i[i], got_l[i], exp_q[i], i, i == 55);
      else n_pass++;
    end
    n_checks++; if (bubbles != 0) $display("FAIL k3_bubbles: got %0d want 0", bubbles); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL k3_done: got valid %b busy %b want 0 0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_edge_k();
    int ks[2] = '{0, 8};
    logic [7:0] w;
    for (int j = 0; j < 2; j++) begin
      w = (ks[j] == 0) ? 8'h00 : 8'hFF;
      do_start(ks[j]);
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_word !== w || out_index !== 7'd0 || out_last !== 1'b1)
        $display("FAIL edge_k%0d_word: got v%b b%b %h %0d l%b want v1 b1 %h 0 l1", ks[j], out_valid, busy, out_word, out_index, out_last, w);
      else n_pass++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL edge_k%0d_done: got valid %b busy %b want 0 0", ks[j], out_valid, busy);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    int ks[2] = '{9, 15};
    for (int j = 0; j < 2; j++) begin
      do_start(ks[j]);
      n_checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL illegal%0d_pulse: got err %b valid %b busy %b want 1 0 0", ks[j], err, out_valid, busy);
      else n_pass++;
      step();
      n_checks++;
      if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL illegal%0d_after: got err %b valid %b busy %b want 0 0 0", ks[j], err, out_valid, busy);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    build_model(2);
    do_start(2);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_word !== 8'h03 || out_index !== 7'd0)
        $display("FAIL stall_hold[%0d]: got v%b %h %0d want v1 03 0", c, out_valid, out_word, out_index);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_word !== 8'h05 || out_index !== 7'd1)
      $display("FAIL stall_advance: got %h %0d want 05 1", out_word, out_index);
    else n_pass++;
    collect(1'b1, 400);
    n_checks++;
    if (timed_out || got_w.size() != 27 || stall_bad != 0)
      $display("FAIL stall_drain: got timeout %b count %0d stall_bad %0d want 0 27 0", timed_out, got_w.size(), stall_bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit hit;
    build_model(4);
    do_start(4);
    start = 1'b1;   // held high while busy: must be ignored
    collect(1'b1, 1000);
    start = 1'b0;
    n_checks++;
    if (timed_out || got_w.size() != 70) $display("FAIL ignore_start_count: got timeout %b count %0d want 0 70", timed_out, got_w.size());
    else n_pass++;
    for (int i = 0; i < got_w.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_w[i] !== exp_q[i]) $display("FAIL ignore_start_word[%0d]: got %h want %h", i, got_w[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ignore_start_idle: got valid %b want 0", out_valid); else n_pass++;

    do_start(4);
    out_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (out_index === 7'd10) begin hit = 1'b1; break; end
      step();
    end
    n_checks++; if (!hit) $display("FAIL midreset_reach: got no index 10 want index 10"); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_word !== 8'h00 || out_index !== 7'd0)
      $display("FAIL midreset_state: got v%b b%b %h %0d want v0 b0 00 0", out_valid, busy, out_word, out_index);
    else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midreset_no_resume: got valid %b want 0", out_valid); else n_pass++;

    build_model(1);
    do_start(1);
    collect(1'b0, 50);
    n_checks++;
    if (timed_out || got_w.size() != 8) $display("FAIL restart_count: got timeout %b count %0d want 0 8", timed_out, got_w.size());
    else n_pass++;
    for (int i = 0; i < got_w.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_w[i] !== exp_q[i]) $display("FAIL restart_word[%0d]: got %h want %h", i, got_w[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random_all_k();
    int bad;
    for (int k = 0; k <= 8; k++) begin
      build_model(k);
      do_start(k);
      collect(1'b1, 2000);
      n_checks++;
      if (timed_out || got_w.size() != exp_q.size())
        $display("FAIL rand_k%0d_count: got timeout %b count %0d want 0 %0d", k, timed_out, got_w.size(), exp_q.size());
      else n_pass++;
      bad = 0;
      for (int i = 0; i < got_w.size(); i++) begin
        if ($countones(got_w[i]) != k) bad++;
        if (i > 0 && got_w[i] <= got_w[i-1]) bad++;
        if (got_i[i] !== 7'(i)) bad++;
        if (got_l[i] !== (i == exp_q.size() - 1)) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL rand_k%0d_rules: got %0d violations want 0", k, bad);
      else n_pass++;
      n_checks++;
      if (stall_bad != 0 || bubbles != 0)
        $display("FAIL rand_k%0d_stream: got stall_bad %0d bubbles %0d want 0 0", k, stall_bad, bubbles);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL rand_k%0d_done: got valid %b busy %b want 0 0", k, out_valid, busy);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_k3_stream();
    test_edge_k();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_random_all_k();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
